// File: rtl/uc_pkg.sv
// Shared codes for the sequential calculator controller.
// Register/ULA control codes, operation modes and FSM states.
package uc_pkg;

   typedef enum logic [1:0] {
      REG_HOLD   = 2'b00,
      REG_LOAD   = 2'b01,
      REG_SHIFTR = 2'b10,
      REG_RESET  = 2'b11
   } reg_op_e;

   typedef enum logic [1:0] {
      ULA_DC  = 2'b00,
      ULA_ADD = 2'b01,
      ULA_SUB = 2'b10
   } ula_op_e;

   typedef enum logic [1:0] {
      MODE_SUM = 2'b00,
      MODE_AVG = 2'b01,
      MODE_SUB = 2'b10,
      MODE_RSV = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_ACC,
      S_FLUSH,
      S_SHIFT,
      S_RES
   } state_e;

   function automatic logic is_pow2(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

   // Bit index of the highest set bit; exact log2 for powers of two.
   function automatic int log2_pow2(input logic [31:0] v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++)
         if (v[i]) r = i;
      return r;
   endfunction

endpackage

// File: rtl/uc_seq_if.sv
// Handshake and control bundle between uc_seq and its datapath.
// The master side issues operations; the slave side is the controller.
interface uc_seq_if
   import uc_pkg::*;
#(
   parameter int MAX_OPS = 8
) ();
   localparam int CNT_W = $clog2(MAX_OPS) + 1;

   logic             start;
   logic [CNT_W-1:0] n_ops;
   logic [1:0]       mode;
   logic             op_valid;
   logic             op_ready;
   reg_op_e          tX;
   reg_op_e          tY;
   reg_op_e          tZ;
   ula_op_e          tULA;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, n_ops, mode, op_valid,
      input  op_ready, tX, tY, tZ, tULA,
      input  busy, done, err
   );

   modport slave (
      input  start, n_ops, mode, op_valid,
      output op_ready, tX, tY, tZ, tULA,
      output busy, done, err
   );
endinterface

// File: rtl/uc_step_cnt.sv
// Loadable down-counter with a terminal-count flag.
// tc_o marks the last step, so the owner can leave on that same edge.
module uc_step_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         tc_o
);
   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: load wins, otherwise decrement without wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = val_i;
      else if (en_i && (cnt_q != '0))
         cnt_d = cnt_q - W'(1);
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == W'(1));
endmodule

// File: rtl/uc_seq.sv
// Autonomous sequencer: clear, accumulate N operands, optional
// averaging shifts, then load the result into Z.
module uc_seq
   import uc_pkg::*;
#(
   parameter int MAX_OPS = 8
) (
   input logic     clk,
   input logic     rst,
   uc_seq_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_OPS) + 1;

   state_e           state_q;
   logic [CNT_W-1:0] n_q;
   mode_e            mode_q;
   logic             err_q;

   logic             start_bad;
   logic             is_sub;
   logic             is_avg;
   logic             multi;
   logic             early;
   logic [CNT_W-1:0] taken;

   logic             cnt_load;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_en;
   logic [CNT_W-1:0] cnt;
   logic             cnt_tc;

   reg_op_e          tx;
   reg_op_e          ty;
   reg_op_e          tz;
   ula_op_e          tula;
   logic             rdy;
   logic             dn;

   assign start_bad = (bus.n_ops == '0)
                   || (32'(bus.n_ops) > MAX_OPS)
                   || ((bus.mode == MODE_AVG)
                       && !is_pow2(32'(bus.n_ops)));

   assign is_sub = (mode_q == MODE_SUB);
   assign is_avg = (mode_q == MODE_AVG);
   assign multi  = (n_q > CNT_W'(1));

   // Acceptances already made; the first two both use ADD.
   assign taken = n_q - cnt;
   assign early = (taken < CNT_W'(2));

   // Counter counts operands in ACC, then shift steps in SHIFT.
   always_comb begin
      cnt_load = 1'b0;
      cnt_val  = n_q;
      cnt_en   = 1'b0;
      if (state_q == S_CLR) begin
         cnt_load = 1'b1;
      end else if (state_q == S_FLUSH) begin
         cnt_load = 1'b1;
         cnt_val  = CNT_W'(log2_pow2(32'(n_q)));
      end else if (state_q == S_ACC) begin
         cnt_en = bus.op_valid;
      end else if (state_q == S_SHIFT) begin
         cnt_en = 1'b1;
      end
   end

   uc_step_cnt #(
      .W(CNT_W)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .load_i (cnt_load),
      .val_i  (cnt_val),
      .en_i   (cnt_en),
      .cnt_o  (cnt),
      .tc_o   (cnt_tc)
   );

   // Sequencer FSM with latched operation parameters and err pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         mode_q  <= MODE_SUM;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  if (start_bad) begin
                     err_q <= 1'b1;
                  end else begin
                     n_q     <= bus.n_ops;
                     mode_q  <= mode_e'(bus.mode);
                     state_q <= S_CLR;
                  end
               end
            end
            S_CLR:   state_q <= S_ACC;
            S_ACC: begin
               if (bus.op_valid && cnt_tc)
                  state_q <= S_FLUSH;
            end
            S_FLUSH: begin
               if (is_avg && multi) state_q <= S_SHIFT;
               else                 state_q <= S_RES;
            end
            S_SHIFT: begin
               if (cnt_tc) state_q <= S_RES;
            end
            S_RES:   state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Control decode; only ACC looks at op_valid.
   always_comb begin
      tx   = REG_HOLD;
      ty   = REG_HOLD;
      tz   = REG_HOLD;
      tula = ULA_DC;
      rdy  = 1'b0;
      dn   = 1'b0;
      unique case (state_q)
         S_IDLE: ;
         S_CLR: begin
            tx = REG_RESET;
            ty = REG_RESET;
            tz = REG_RESET;
         end
         S_ACC: begin
            rdy = 1'b1;
            if (bus.op_valid) begin
               tx = REG_LOAD;
               ty = REG_LOAD;
               if (early || !is_sub) tula = ULA_ADD;
               else                  tula = ULA_SUB;
            end
         end
         S_FLUSH: begin
            ty = REG_LOAD;
            if (is_sub && multi) tula = ULA_SUB;
            else                 tula = ULA_ADD;
         end
         S_SHIFT: ty = REG_SHIFTR;
         S_RES: begin
            tz = REG_LOAD;
            dn = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.tX       = tx;
   assign bus.tY       = ty;
   assign bus.tZ       = tz;
   assign bus.tULA     = tula;
   assign bus.op_ready = rdy;
   assign bus.done     = dn;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.err      = err_q;
endmodule

// File: tb/tb_uc_seq.sv
// Scoreboard bench for uc_seq with a small X/Y/Z datapath model.
// Stimulus pushes expectations; a negedge monitor checks on done.
`timescale 1ns/1ps
module tb_uc_seq;
   import uc_pkg::*;

   typedef struct {
      int z;
      int lat;
      int seq;
      int shf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] opnd = '0;
   logic [15:0] xm = '0;
   logic [15:0] ym = '0;
   logic [15:0] zm = '0;
   int          cyc = 0;
   int          s0 = 0;
   int          vecs = 0;
   int          miss = 0;
   exp_t        sb[$];

   uc_seq_if #(.MAX_OPS(8)) bus ();

   uc_seq #(.MAX_OPS(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   wire [11:0] ov = {bus.op_ready, bus.busy, bus.done, bus.err,
                     bus.tX, bus.tY, bus.tZ, bus.tULA};

   task automatic chk(input string nm, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         miss++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Datapath model reacting to the control codes.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      case (bus.tX)
         REG_LOAD:  xm <= opnd;
         REG_RESET: xm <= '0;
         default: ;
      endcase
      case (bus.tY)
         REG_LOAD:   ym <= (bus.tULA == ULA_SUB) ? ym - xm : ym + xm;
         REG_SHIFTR: ym <= ym >> 1;
         REG_RESET:  ym <= '0;
         default: ;
      endcase
      case (bus.tZ)
         REG_LOAD:  zm <= ym;
         REG_RESET: zm <= '0;
         default: ;
      endcase
   end

   int   seq = 0;
   int   shf = 0;
   bit   zchk = 0;
   exp_t pend;

   // Monitor: trace ULA/shift activity, compare on each done.
   always @(negedge clk) begin
      if (zchk) begin
         chk("z_result", int'(zm), pend.z);
         zchk = 0;
      end
      if (bus.tX == REG_RESET) begin
         seq = 0;
         shf = 0;
      end
      if (bus.tY == REG_LOAD) seq = (seq << 2) | int'(bus.tULA);
      if (bus.tY == REG_SHIFTR) shf++;
      if (bus.done) begin
         if (sb.size() == 0) begin
            vecs++;
            miss++;
            $display("FAIL done: unexpected pulse at cycle %0d", cyc);
         end else begin
            pend = sb.pop_front();
            chk("latency", cyc - s0, pend.lat);
            chk("ula_seq", seq, pend.seq);
            chk("shifts", shf, pend.shf);
            zchk = 1;
         end
      end
   end

   task automatic run_op(input logic [1:0] m, input int n,
                         input int ops[4], input logic [15:0] vpat,
                         input bit poke, input exp_t e);
      int i = 0;
      int k = 0;
      int g = 0;
      bit fin = 0;
      sb.push_back(e);
      tick();
      bus.start = 1'b1;
      bus.n_ops = 4'(n);
      bus.mode  = m;
      s0 = cyc;
      tick();
      bus.start = 1'b0;
      while (!fin && g < 64) begin
         if (bus.done) fin = 1;
         if (bus.op_ready && k < 16) begin
            bus.op_valid = vpat[k];
            if (i < 4) opnd = 16'(ops[i]);
            if (vpat[k]) i++;
            if (poke && k == 1) begin
               bus.start = 1'b1;
               bus.n_ops = 4'd4;
               bus.mode  = MODE_AVG;
            end
            k++;
         end else begin
            bus.op_valid = 1'b0;
         end
         g++;
         tick();
         bus.start = 1'b0;
      end
      bus.op_valid = 1'b0;
      if (!fin) begin
         vecs++;
         miss++;
         $display("FAIL timeout: no done for mode %0d n %0d", m, n);
         sb.delete();
      end
      tick();
      tick();
   endtask

   task automatic rej(input logic [1:0] m, input int n,
                      input string nm);
      tick();
      bus.start = 1'b1;
      bus.n_ops = 4'(n);
      bus.mode  = m;
      tick();
      bus.start = 1'b0;
      chk({nm, "_err"}, int'(ov), 'h100);
      tick();
      chk({nm, "_after"}, int'(ov), 0);
      tick();
      chk({nm, "_idle"}, int'(ov), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start    = 1'b0;
      bus.n_ops    = '0;
      bus.mode     = 2'b00;
      bus.op_valid = 1'b0;
      rst = 1'b1;
      tick();
      chk("reset_state", int'(ov), 0);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("idle", int'(ov), 0);
      end

      run_op(MODE_SUM, 3, '{5, 7, 9, 0}, 16'hFFFF, 0,
             '{21, 6, 'h55, 0});

      // Reset in the middle of ACC.
      tick();
      bus.start = 1'b1;
      bus.n_ops = 4'd3;
      bus.mode  = MODE_SUM;
      tick();
      bus.start = 1'b0;
      tick();
      bus.op_valid = 1'b1;
      opnd = 16'd5;
      #1;
      chk("acc_live", int'(ov), 'hC51);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_in_acc", int'(ov), 0);
      bus.op_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst", int'(ov), 0);
      chk("z_no_partial", int'(zm), 0);

      run_op(MODE_AVG, 4, '{2, 4, 6, 8}, 16'hFFFF, 0,
             '{5, 9, 'h155, 2});
      run_op(MODE_SUB, 3, '{20, 5, 3, 0}, 16'hFFFF, 0,
             '{12, 6, 'h5A, 0});

      rej(MODE_AVG, 3, "rej_avg3");
      rej(MODE_SUM, 0, "rej_n0");
      rej(MODE_SUM, 9, "rej_n9");

      run_op(MODE_AVG, 1, '{7, 0, 0, 0}, 16'hFFFF, 0,
             '{7, 4, 'h5, 0});
      run_op(MODE_SUM, 2, '{10, 3, 0, 0}, 16'h0009, 1,
             '{13, 7, 'h15, 0});

      tick();
      chk("idle_end", int'(ov), 0);
      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vecs, miss);
      $finish;
   end
endmodule

// File: doc/uc_seq.md
# uc_seq

Parametrised, sequential successor to the calculator control unit. Instead of decoding one externally supplied function code per cycle, it runs a whole operation autonomously: it clears the X/Y/Z registers and accepts N operands through a valid/ready handshake. It accumulates them through the ULA, then for averaging right-shifts the result log2(N) times and loads it into Z. It drives the same X/Y/Z register control codes and ULA select as the existing datapath.

## Interface
Parameters:
- MAX_OPS, 8, maximum operand count; power of two, ≥2
- CNT_W, $clog2(MAX_OPS)+1, width of n_ops and internal counters (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request a new operation; sampled only in IDLE
- n_ops  in  CNT_W  operand count, sampled with start
- mode  in  2  00 SUM, 01 AVG, 10 SUB (first operand minus the rest), 11 treated as SUM
- op_valid  in  1  operand present on datapath input
- op_ready  out  1  controller accepts an operand this cycle
- tX, tY, tZ  out  2 each  register control: 00 HOLD, 01 LOAD, 10 SHIFTR, 11 RESET
- tULA  out  2  00 DC, 01 ADD, 10 SUB
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, high in RES
- err  out  1  one-cycle pulse on a rejected start

## Operation
- Datapath contract: X loads the external operand. Y loads ULA(Y, X) on LOAD and shifts right on SHIFTR. Z loads Y.
- States: IDLE, CLR, ACC, FLUSH, SHIFT, RES.
- IDLE: all controls HOLD, tULA DC, op_ready 0.
  - A start is rejected, with err pulsed next cycle and the controller staying in IDLE, if n_ops==0, n_ops>MAX_OPS, or mode AVG with n_ops not a power of two.
  - Otherwise the controller latches n_ops and mode and goes to CLR.
- CLR: tX=tY=tZ=RESET for one cycle, then ACC.
- ACC: op_ready=1. Each cycle with op_valid=1 is an acceptance: tX=LOAD, tY=LOAD, and the accept counter increments. With op_valid=0, all controls HOLD.
  - X is one operand behind Y.
  - For acceptance k (1-based): tULA=ADD if k≤2 or mode≠SUB; otherwise SUB.
  - After the n-th acceptance, go to FLUSH.
- FLUSH: tX=HOLD, tY=LOAD, op_ready=0. tULA=SUB if mode SUB and n≥2; otherwise ADD.
- FLUSH exit: to SHIFT if mode AVG and n≥2; otherwise to RES.
- SHIFT: tY=SHIFTR for log2(n) consecutive cycles, then RES.
- RES: tZ=LOAD, done=1, one cycle, then IDLE.
- tX/tY/tULA in ACC depend combinationally on op_valid. All other outputs are decoded from the state only.
- start asserted while busy is ignored.
- Arithmetic width and overflow belong to the datapath. The controller imposes no saturation.

## Timing
- Reset values (applied asynchronously): state IDLE; tX=tY=tZ=HOLD, tULA=DC, op_ready=0, busy=0, done=0, err=0; counters 0.
- With op_valid held high, counting the start-sampling edge as edge 0:
  - CLR in cycle 1
  - ACC in cycles 2..n+1
  - FLUSH in cycle n+2
  - SHIFT in cycles n+3..n+2+s, where s=log2(n) for AVG, else 0
  - RES/done in cycle n+3+s
- op_valid gaps stretch ACC one cycle per idle cycle. No upper bound on wait.
- rst asserted mid-operation returns every output to its reset value immediately. No partial result is loaded into Z.
- A new start is accepted in the first IDLE cycle after RES.

## Structure
- Shared package uc_pkg holds:
  - register codes HOLD/LOAD/SHIFTR/RESET
  - ULA codes DC/ADD/SUB
  - mode codes
  - the state enumeration
- One sub-module, uc_step_cnt: a loadable counter with a terminal-count flag. It counts acceptances in ACC and shift steps in SHIFT.

## Test plan
- Reset, then idle 5 cycles: all controls HOLD/DC, busy/done/err 0. Assert rst during ACC: outputs revert the same cycle.
- SUM, n=3, operands 5,7,9 back-to-back, with the bench datapath model: Z=21; done in cycle 6 after start; the ULA sequence across the three acceptances and FLUSH is ADD, ADD, ADD, ADD.
- AVG, n=4, operands 2,4,6,8: exactly 2 SHIFTR cycles; Z=5; done in cycle 9.
- SUB, n=3, operands 20,5,3: tULA sequence ADD, ADD, SUB, then FLUSH SUB; Z=12.
- Rejected starts: AVG n=3, n=0, and n=9 with MAX_OPS=8. Each gives one err pulse; busy stays 0; no control leaves HOLD.
- AVG, n=1, operand 7: no SHIFT state; Z=7. Then SUM n=2 with op_valid toggling 1,0,0,1: done delayed by exactly 2 cycles; start pulses during busy are ignored.
